lfsr_checker: RTL



---
 rtl/lfsr_checker.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/lfsr_checker.sv
// Receive-side checker for the LFSR data/address test stream.
// Self-seeds from the stream, locks after consecutive matches and counts errors.
module lfsr_checker #(
  parameter int unsigned LOCK_WORDS  = 4,
  parameter int unsigned UNLOCK_ERRS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic [9:0]  in_addr,
  input  logic        clear,
  output logic        locked,
  output logic        err_pulse,
  output logic        err_sticky,
  output logic [31:0] word_count,
  output logic [15:0] err_count
);

  typedef enum logic [1:0] {
    UNSEEDED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  function automatic logic [31:0] next32(input logic [31:0] s);
    logic [31:0] n;
    n     = {s[30:0], s[31]};
    n[1]  = s[0] ^ s[31];
    n[2]  = s[1] ^ s[31];
    n[22] = s[21] ^ s[31];
    return n;
  endfunction

  function automatic logic [9:0] next10(input logic [9:0] s);
    logic [9:0] n;
    n    = {s[8:0], s[9]};
    n[3] = s[2] ^ s[9];
    return n;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] exp_d_q, exp_d_d;
  logic [9:0]  exp_a_q, exp_a_d;
  logic [7:0]  match_cnt_q, match_cnt_d;
  logic [7:0]  consec_err_q, consec_err_d;
  logic [31:0] word_count_q, word_count_d;
  logic [15:0] err_count_q, err_count_d;
  logic        sticky_q, sticky_d;
  logic        pulse_q, pulse_d;
  logic        locked_q, locked_d;

  logic        match;
  logic [7:0]  match_inc;
  logic [7:0]  err_inc;

  assign match     = (in_data == exp_d_q) && (in_addr == exp_a_q);
  assign match_inc = match_cnt_q + 8'd1;
  assign err_inc   = consec_err_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    exp_d_d      = exp_d_q;
    exp_a_d      = exp_a_q;
    match_cnt_d  = match_cnt_q;
    consec_err_d = consec_err_q;
    word_count_d = word_count_q;
    err_count_d  = err_count_q;
    sticky_d     = sticky_q;
    pulse_d      = 1'b0;
    if (clear) begin
      state_d      = UNSEEDED;
      word_count_d = '0;
      err_count_d  = '0;
      sticky_d     = 1'b0;
    end else if (in_valid) begin
      unique case (state_q)
        UNSEEDED: begin
          exp_d_d     = next32(in_data);
          exp_a_d     = next10(in_addr);
          match_cnt_d = '0;
          state_d     = ACQUIRE;
        end
        ACQUIRE: begin
          if (match) begin
            exp_d_d     = next32(exp_d_q);
            exp_a_d     = next10(exp_a_q);
            match_cnt_d = match_inc;
            if (match_inc == 8'(LOCK_WORDS)) begin
              state_d      = LOCKED;
              consec_err_d = '0;
            end
          end else begin
            // Mismatch while acquiring just means a bad seed: restart silently
            exp_d_d     = next32(in_data);
            exp_a_d     = next10(in_addr);
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          exp_d_d = next32(exp_d_q);
          exp_a_d = next10(exp_a_q);
          if (word_count_q != 32'hFFFF_FFFF)
            word_count_d = word_count_q + 32'd1;
          if (match) begin
            consec_err_d = '0;
          end else begin
            pulse_d      = 1'b1;
            sticky_d     = 1'b1;
            consec_err_d = err_inc;
            if (err_count_q != 16'hFFFF)
              err_count_d = err_count_q + 16'd1;
            if (err_inc == 8'(UNLOCK_ERRS))
              state_d = UNSEEDED;
          end
        end
        default: state_d = UNSEEDED;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= UNSEEDED;
      exp_d_q      <= 32'hFFFF_FFFF;
      exp_a_q      <= 10'h3FF;
      match_cnt_q  <= '0;
      consec_err_q <= '0;
      word_count_q <= '0;
      err_count_q  <= '0;
      sticky_q     <= 1'b0;
      pulse_q      <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_d_q      <= exp_d_d;
      exp_a_q      <= exp_a_d;
      match_cnt_q  <= match_cnt_d;
      consec_err_q <= consec_err_d;
      word_count_q <= word_count_d;
      err_count_q  <= err_count_d;
      sticky_q     <= sticky_d;
      pulse_q      <= pulse_d;
      locked_q     <= locked_d;
    end
  end

  assign locked     = locked_q;
  assign err_pulse  = pulse_q;
  assign err_sticky = sticky_q;
  assign word_count = word_count_q;
  assign err_count  = err_count_q;

endmodule
